// File: rtl/pipe_stage_chain_if.sv
// pipe_stage_chain_if: handshake, control and debug signals of the elastic pipeline chain
interface pipe_stage_chain_if #(
    parameter int WIDTH = 32,
    parameter int PC_W  = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
);
    localparam int OW = $clog2(DEPTH + 1);
    logic             freeze;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [PC_W-1:0]  in_pc;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [PC_W-1:0]  out_pc;
    logic [WIDTH-1:0] out_data;
    logic [OW-1:0]    occupancy;
    logic [CNT_W-1:0] stall_cnt;
    modport master (
        output freeze, flush, in_valid, in_pc, in_data, out_ready,
        input  in_ready, out_valid, out_pc, out_data, occupancy, stall_cnt
    );
    modport slave (
        input  freeze, flush, in_valid, in_pc, in_data, out_ready,
        output in_ready, out_valid, out_pc, out_data, occupancy, stall_cnt
    );
endinterface

// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: elastic PC/payload register chain with freeze, flush, backpressure and bubble collapsing
module pipe_stage_chain #(
    parameter int WIDTH = 32,
    parameter int PC_W  = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input logic               clk,
    input logic               rst,
    pipe_stage_chain_if.slave bus
);
    localparam int OW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]             v_q, v_d;
    logic [DEPTH-1:0][PC_W-1:0]   pc_q, pc_d;
    logic [DEPTH-1:0][WIDTH-1:0]  data_q, data_d;
    logic [OW-1:0]                occ_q, occ_d;
    logic [CNT_W-1:0]             stall_q, stall_d;
    logic                         run_q;
    logic [DEPTH-1:0]             adv;
    logic                         rdy, acc, xfer;

    // A slot may move when downstream takes the oldest entry or any slot at or after it is empty.
    for (genvar g = 0; g < DEPTH; g++) begin : g_adv
        assign adv[g] = bus.out_ready | ~&v_q[DEPTH-1:g];
    end

    // run_q blocks transfers on the reset-release edge.
    assign rdy  = rst & run_q & !bus.freeze & !bus.flush & adv[0];
    assign acc  = bus.in_valid & rdy;
    assign xfer = v_q[DEPTH-1] & bus.out_ready & run_q & !bus.freeze & !bus.flush;

    assign bus.in_ready  = rdy;
    assign bus.out_valid = v_q[DEPTH-1];
    assign bus.out_pc    = pc_q[DEPTH-1];
    assign bus.out_data  = data_q[DEPTH-1];
    assign bus.occupancy = occ_q;
    assign bus.stall_cnt = stall_q;

    // Next slot contents: flush clears, freeze holds, otherwise shift forward collapsing bubbles.
    always_comb begin
        v_d    = v_q;
        pc_d   = pc_q;
        data_d = data_q;
        if (bus.flush) begin
            v_d    = '0;
            pc_d   = '0;
            data_d = '0;
        end else if (!bus.freeze && run_q) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                if (adv[i]) begin
                    v_d[i]    = v_q[i-1];
                    pc_d[i]   = pc_q[i-1];
                    data_d[i] = data_q[i-1];
                end
            end
            if (adv[0]) begin
                v_d[0]    = acc;
                pc_d[0]   = acc ? bus.in_pc : '0;
                data_d[0] = acc ? bus.in_data : '0;
            end
        end
        occ_d   = bus.flush ? '0 : occ_q + OW'(acc) - OW'(xfer);
        stall_d = (run_q && (bus.freeze || (v_q[DEPTH-1] && !bus.out_ready)) && !(&stall_q))
                  ? stall_q + CNT_W'(1) : stall_q;
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_q     <= '0;
            pc_q    <= '0;
            data_q  <= '0;
            occ_q   <= '0;
            stall_q <= '0;
            run_q   <= 1'b0;
        end else begin
            v_q     <= v_d;
            pc_q    <= pc_d;
            data_q  <= data_d;
            occ_q   <= occ_d;
            stall_q <= stall_d;
            run_q   <= 1'b1;
        end
    end
endmodule

// File: doc/pipe_stage_chain.md
Name: pipe_stage_chain

Overview:
- Parametrised elastic pipeline register chain that replaces the fixed per-stage PC/instruction registers between pipeline stages.
- Carries a PC and a payload through DEPTH register slots, each with a valid bit.
- Supports global freeze (stall), flush (branch kill), downstream backpressure and bubble collapsing.
- Exports occupancy and a saturating stall counter for debug display on the board LEDs and 7-segment displays.

Parameters:
- WIDTH, 32, payload width in bits (instruction/control bundle).
- PC_W, 32, PC field width in bits.
- DEPTH, 4, number of register slots (minimum 1).
- CNT_W, 16, width of the stall counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- freeze  in  1  hold all slots; no transfer in or out.
- flush  in  1  invalidate all slots.
- in_valid  in  1  upstream has an entry.
- in_ready  out  1  chain accepts an entry this cycle.
- in_pc  in  PC_W  upstream PC.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  slot DEPTH-1 holds a valid entry.
- out_ready  in  1  downstream accepts this cycle.
- out_pc  out  PC_W  PC of the oldest slot.
- out_data  out  WIDTH  payload of the oldest slot.
- occupancy  out  clog2(DEPTH+1)  number of valid slots.
- stall_cnt  out  CNT_W  saturating count of stalled cycles.

Behaviour:
- Reset (rst=0, async):
  - All valid bits, pc and data registers, occupancy and stall_cnt go to 0.
  - out_valid=0, out_pc=0, out_data=0.
  - in_ready=0 while rst=0.
  - Release is synchronous to the next clk edge; no transfer on the release edge.
- Slots are numbered 0 (input side) to DEPTH-1 (output side). out_* are driven directly from slot DEPTH-1 registers, with no combinational path from in_* to out_*.
- Advance rule, with freeze=0 and flush=0:
  - adv[DEPTH-1] = !v[DEPTH-1] | out_ready.
  - adv[i] = !v[i] | adv[i+1] for i < DEPTH-1.
  - On clk, slot i+1 loads slot i when adv[i+1]=1. The loaded valid is v[i], so bubbles collapse.
  - Slot 0 loads in_* with valid = in_valid & in_ready.
  - in_ready = !freeze & !flush & adv[0] (combinational from out_ready).
- Latency: an entry accepted at edge N appears on out_* after edge N+DEPTH-1 when there are no stalls, i.e. DEPTH cycles from in to out registered.
- Throughput: one entry per cycle when out_ready=1 continuously.
- Backpressure: out_ready=0 with all slots valid gives in_ready=0 and all slots hold. Empty slots still fill from upstream until the chain is full.
- freeze=1:
  - Every register holds and in_ready=0.
  - out_valid holds its value; the downstream must not count a transfer while freeze=1.
- flush=1:
  - At the next edge all valid bits clear and pc/data registers clear to 0.
  - The in_* entry is dropped.
  - occupancy becomes 0 at that edge.
- Priority: rst > flush > freeze > normal advance. flush together with freeze still clears.
- Handshake: a transfer out occurs only when out_valid & out_ready & !freeze & !flush. The upstream must hold in_* stable while in_valid=1 and in_ready=0.
- occupancy is a registered popcount of the valid bits: +1 on accept without output transfer, -1 on output transfer without accept, unchanged when both or neither occur. Range is 0..DEPTH.
- stall_cnt increments by 1 each cycle where (freeze=1) or (out_valid=1 & out_ready=0). It saturates at 2^CNT_W-1 and is cleared only by reset; flush does not clear it.
- DEPTH=1: a single slot; adv[0] = !v[0] | out_ready, all other rules unchanged.

Test Plan:
- Stream: DEPTH=4, out_ready=1, in_valid=1 with pc 0,4,8,...,28 and data=pc+0x1000 -> first out_valid at cycle 4, out_pc=0, out_data=0x1000, then one entry per cycle in order; occupancy settles at 4; stall_cnt=0.
- Backpressure: fill 4 entries, out_ready=0 for 5 cycles -> in_ready=0, out_pc held at first pc, stall_cnt=5; out_ready=1 -> 4 entries drain in order.
- Bubble collapse: accept pc=0x10, idle 2 cycles, accept pc=0x14 with out_ready=0 -> both stack in slots 3 and 2; occupancy=2; order preserved on release.
- Flush: full chain, assert flush with in_valid=1, pc=0x40 -> next cycle out_valid=0, occupancy=0, out_pc=0, pc 0x40 not emitted; stall_cnt unchanged.
- Freeze: freeze=1 for 3 cycles mid-stream -> in_ready=0, all outputs constant, stall_cnt +3; release resumes with no lost or duplicate pc.
- Async reset mid-stream: drop rst between clock edges -> out_valid, occupancy and stall_cnt read 0 immediately, without waiting for a clk edge; after release, the first accepted entry emerges DEPTH cycles later.
